// File: rtl/vga_frame_reader_pkg.sv
// rtl/vga_frame_reader_pkg.sv - 640x480@60 VGA timing, board window geometry and reader FSM encoding
package vga_frame_reader_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FP     = 10'd16;
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BP     = 10'd48;
    localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FP     = 10'd10;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BP     = 10'd33;
    localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
    localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;
    localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;
    localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;

    // 120x120 board scaled 4x, horizontally centred from column 80
    localparam logic [9:0] WIN_X0      = 10'd80;
    localparam int         SCALE_SHIFT = 2;
    localparam logic [9:0] FB_DIM      = 10'd120;
    localparam logic [9:0] WIN_X1      = WIN_X0 + (FB_DIM << SCALE_SHIFT) - 10'd1;
    localparam logic [9:0] BORDER_W    = 10'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
        logic win;
        logic border;
        logic show;
    } pix_tag_t;

    localparam pix_tag_t TAG_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0,
                                      win: 1'b0, border: 1'b0, show: 1'b0};

    // Column-major address x*120 + y, built from shifts so no multiplier is needed
    function automatic logic [14:0] fb_addr(input logic [6:0] fb_x, input logic [6:0] fb_y);
        logic [14:0] x;
        x = {8'd0, fb_x};
        return (x << 7) - (x << 3) + {8'd0, fb_y};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running VGA h/v counters with raw sync, active and frame_start
module vga_timing_gen
    import vga_frame_reader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       hs,
    output logic       vs,
    output logic       active,
    output logic       frame_start
);

    logic h_wrap;
    logic v_wrap;

    assign h_wrap = (hcnt == H_LAST);
    assign v_wrap = (vcnt == V_LAST);

    // frame_start is registered so it stays low while reset holds the counters at 0,0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt        <= '0;
            vcnt        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= h_wrap && v_wrap;
            if (h_wrap) begin
                hcnt <= '0;
                vcnt <= v_wrap ? '0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    assign hs     = !((hcnt >= H_SYNC_START) && (hcnt <= H_SYNC_END));
    assign vs     = !((vcnt >= V_SYNC_START) && (vcnt <= V_SYNC_END));
    assign active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE);

endmodule

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - scans a 120x120 frame buffer onto VGA; VGA_FRAME_READER_BORDER_EN adds a window outline
module vga_frame_reader
    import vga_frame_reader_pkg::*;
#(
    parameter int          READ_LATENCY = 2,
    parameter logic [23:0] BG_COLOR     = 24'h000000,
    parameter logic [23:0] BORDER_COLOR = 24'h808080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [14:0] rd_addr,
    output logic        rd_en,
    input  logic [23:0] rd_data,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        frame_start
);

`ifdef VGA_FRAME_READER_BORDER_EN
    localparam logic BORDER_EN = 1'b1;
`else
    localparam logic BORDER_EN = 1'b0;
`endif
    localparam logic [23:0] EDGE_COLOR = BORDER_EN ? BORDER_COLOR : BG_COLOR;

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       hs_raw;
    logic       vs_raw;
    logic       active_raw;

    vga_timing_gen u_timing (
        .clk         (clk),
        .rst         (rst),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .hs          (hs_raw),
        .vs          (vs_raw),
        .active      (active_raw),
        .frame_start (frame_start)
    );

    state_t     state;
    state_t     state_nx;
    logic       frame_end;
    logic       scanning;
    logic       in_win;
    logic       in_border;
    logic       rd_en_c;
    logic [6:0] fb_x;
    logic [6:0] fb_y;
    pix_tag_t   tag_c;
    pix_tag_t   tag_out;
    pix_tag_t   pipe [0:READ_LATENCY];
    logic [23:0] pix;

    assign frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Scanning only starts and stops on frame boundaries, so no partial frame is ever shown
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (enable) state_nx = ST_ARM;
            ST_ARM:   if (frame_end) state_nx = ST_RUN;
            ST_RUN:   if (!enable) state_nx = ST_DRAIN;
            ST_DRAIN: begin
                if (enable) begin
                    state_nx = ST_RUN;
                end else if (frame_end) begin
                    state_nx = ST_IDLE;
                end
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign scanning  = (state == ST_RUN) || (state == ST_DRAIN);
    assign in_win    = (hcnt >= WIN_X0) && (hcnt <= WIN_X1) && (vcnt < V_ACTIVE);
    assign in_border = BORDER_EN && (vcnt < V_ACTIVE) &&
                       (((hcnt >= WIN_X0 - BORDER_W) && (hcnt < WIN_X0)) ||
                        ((hcnt > WIN_X1) && (hcnt <= WIN_X1 + BORDER_W)));
    assign fb_x      = 7'((hcnt - WIN_X0) >> SCALE_SHIFT);
    assign fb_y      = 7'(vcnt >> SCALE_SHIFT);
    assign rd_en_c   = in_win && scanning;

    assign tag_c = '{hs: hs_raw, vs: vs_raw, blank_n: active_raw,
                     win: in_win, border: in_border, show: scanning};

    // pipe[0] travels alongside rd_addr; pipe[READ_LATENCY] meets the returned rd_data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr <= '0;
            rd_en   <= 1'b0;
            for (int i = 0; i <= READ_LATENCY; i++) begin
                pipe[i] <= TAG_IDLE;
            end
        end else begin
            rd_en <= rd_en_c;
            if (rd_en_c) begin
                rd_addr <= fb_addr(fb_x, fb_y);
            end
            pipe[0] <= tag_c;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                pipe[i] <= pipe[i - 1];
            end
        end
    end

    assign tag_out = pipe[READ_LATENCY];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix         <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else begin
            vga_hs      <= tag_out.hs;
            vga_vs      <= tag_out.vs;
            vga_blank_n <= tag_out.blank_n;
            if (!tag_out.show || !tag_out.blank_n) begin
                pix <= '0;
            end else if (tag_out.win) begin
                pix <= rd_data;
            end else if (tag_out.border) begin
                pix <= EDGE_COLOR;
            end else begin
                pix <= BG_COLOR;
            end
        end
    end

    assign vga_r = pix[23:16];
    assign vga_g = pix[15:8];
    assign vga_b = pix[7:0];

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - self-checking bench for vga_frame_reader against a frame-level reference model
module tb_vga_frame_reader;

    localparam int          RL     = 2;
    localparam int          LAT    = RL + 2;
    localparam int          LINE   = 800;
    localparam int          FRAME  = 800 * 525;
    localparam logic [23:0] BG     = 24'h102030;
    localparam logic [23:0] BORDER = 24'h808080;
`ifdef VGA_FRAME_READER_BORDER_EN
    localparam bit BORDER_ON = 1'b1;
`else
    localparam bit BORDER_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [14:0] rd_addr;
    logic        rd_en;
    logic [23:0] rd_data;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        frame_start;
    logic [23:0] pix;

    int n;
    int total;
    int bad;
    int scan_frame;
    int hs_low;
    int vs_low;

    always #5 clk = ~clk;

    vga_frame_reader #(
        .READ_LATENCY (RL),
        .BG_COLOR     (BG),
        .BORDER_COLOR (BORDER)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .rd_addr     (rd_addr),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .frame_start (frame_start)
    );

    assign pix = {vga_r, vga_g, vga_b};

    // Frame buffer whose content equals its address, returned RL cycles after the address
    logic [23:0] mem_q [RL];
    always @(posedge clk) begin
        mem_q[0] <= {9'd0, rd_addr};
        for (int i = 1; i < RL; i++) mem_q[i] <= mem_q[i - 1];
    end
    assign rd_data = mem_q[RL - 1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
            if (bad >= 100) begin
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    endtask

    // Pixel the screen must show for counter position k (cycles since reset release)
    function automatic logic [23:0] exp_pixel(input int k);
        int h;
        int v;
        h = k % LINE;
        v = (k / LINE) % 525;
        if (h >= 640 || v >= 480 || (k / FRAME) != scan_frame) return 24'd0;
        if (h >= 80 && h < 560) return 24'(((h - 80) / 4) * 120 + v / 4);
        if (BORDER_ON && ((h >= 76 && h < 80) || (h >= 560 && h < 564))) return BORDER;
        return BG;
    endfunction

    task automatic check_cycle();
        int   k;
        int   h;
        int   v;
        logic exp_en;
        k = n - LAT;
        if (k < 0) begin
            chk("hs", 32'(vga_hs), 32'd1);
            chk("vs", 32'(vga_vs), 32'd1);
            chk("blank_n", 32'(vga_blank_n), 32'd0);
            chk("pixel", 32'(pix), 32'd0);
        end else begin
            h = k % LINE;
            v = (k / LINE) % 525;
            chk("hs", 32'(vga_hs), 32'(!(h >= 656 && h <= 751)));
            chk("vs", 32'(vga_vs), 32'(!(v == 490 || v == 491)));
            chk("blank_n", 32'(vga_blank_n), 32'(h < 640 && v < 480));
            chk("pixel", 32'(pix), 32'(exp_pixel(k)));
        end
        k = n - 1;
        exp_en = 1'b0;
        h = 0;
        v = 0;
        if (k >= 0) begin
            h = k % LINE;
            v = (k / LINE) % 525;
            exp_en = ((k / FRAME) == scan_frame) && h >= 80 && h < 560 && v < 480;
        end
        chk("rd_en", 32'(rd_en), 32'(exp_en));
        if (exp_en) chk("rd_addr", 32'(rd_addr), 32'(((h - 80) / 4) * 120 + v / 4));
        chk("frame_start", 32'(frame_start), 32'(n > 0 && (n % FRAME) == 0));
        if (vga_hs === 1'b0) hs_low++;
        if (vga_vs === 1'b0) vs_low++;
        if ((n % LINE) == LINE - 1) begin
            chk("hs_low_per_line", 32'(hs_low), 32'd96);
            hs_low = 0;
        end
        if ((n % FRAME) == FRAME - 1) begin
            chk("vs_low_per_frame", 32'(vs_low), 32'd1600);
            vs_low = 0;
        end
    endtask

    // Spot values quoted directly from the scan-out rules
    task automatic spot_checks();
        if (n == FRAME + 80 + 1) begin
            chk("first_rd_en", 32'(rd_en), 32'd1);
            chk("first_addr", 32'(rd_addr), 32'd0);
        end
        if (n == FRAME + 479 * LINE + 559 + 1) chk("last_addr", 32'(rd_addr), 32'd14399);
        if (n == FRAME + 8 * LINE + 84 + LAT) begin
            chk("px_84_8", 32'(pix), 32'h00007A);
            chk("blank_84_8", 32'(vga_blank_n), 32'd1);
        end
        if (n == FRAME + 10 * LINE + 77 + 1) chk("edge_no_read", 32'(rd_en), 32'd0);
        if (n == FRAME + 10 * LINE + 76 + LAT) chk("edge_left", 32'(pix), 32'(BORDER_ON ? BORDER : BG));
        if (n == FRAME + 10 * LINE + 563 + LAT) chk("edge_right", 32'(pix), 32'(BORDER_ON ? BORDER : BG));
        if (n == 2 * FRAME + 5 * LINE + 100 + LAT) chk("idle_px", 32'(pix), 32'd0);
    endtask

    task automatic run_to(input int target);
        while (n < target) begin
            spot_checks();
            check_cycle();
            @(negedge clk);
            n++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pixel"}, 32'(pix), 32'd0);
        chk({tag, "_hs"}, 32'(vga_hs), 32'd1);
        chk({tag, "_vs"}, 32'(vga_vs), 32'd1);
        chk({tag, "_blank_n"}, 32'(vga_blank_n), 32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    endtask

    initial begin
        int t;
        rst        = 1'b0;
        enable     = 1'b0;
        n          = 0;
        total      = 0;
        bad        = 0;
        scan_frame = -1;
        hs_low     = 0;
        vs_low     = 0;

        repeat (3) @(negedge clk);
        chk_reset("por");
        rst = 1'b1;

        // Idle scan with enable low, then a mid-frame reset at hcnt=300, vcnt=100
        run_to(100 * LINE + 300);
        rst = 1'b0;
        #1;
        chk_reset("rst_async");
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_reset("rst_hold");
        end
        @(negedge clk);
        rst        = 1'b1;
        n          = 0;
        hs_low     = 0;
        vs_low     = 0;
        scan_frame = 1;

        // Enable mid-frame: this frame stays dark, the next one is read out
        t = LINE * int'($urandom_range(400, 100)) + int'($urandom_range(799, 0));
        run_to(t);
        enable = 1'b1;
        run_to(FRAME);

        // Drop enable in line 200, briefly restore it, drop again: the whole frame is still read
        t = FRAME + 200 * LINE + int'($urandom_range(799, 0));
        run_to(t);
        enable = 1'b0;
        t = FRAME + 250 * LINE + int'($urandom_range(799, 0));
        run_to(t);
        enable = 1'b1;
        t = FRAME + 300 * LINE + int'($urandom_range(799, 0));
        run_to(t);
        enable = 1'b0;

        // Following frame must be all-zero colour with no reads
        run_to(2 * FRAME + 40 * LINE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_frame_reader.md
VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2, meaning clk cycles from rd_addr/rd_en to valid rd_data (legal range 1..4).
REQ-002 SHALL have parameter BG_COLOR, default 24'h000000, meaning the colour of active pixels outside the board window.
REQ-003 SHALL have parameter BORDER_COLOR, default 24'h808080, meaning the frame outline colour (used only with the border feature).
REQ-004 clk  in  1  pixel clock, 25.175 MHz.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  request to scan the frame buffer out.
REQ-007 rd_addr  out  15  frame-buffer read address; addr = fb_x*120 + fb_y (column-major, 120x120).
REQ-008 rd_en  out  1  read strobe.
REQ-009 rd_data  in  24  8-bit R, G, B, valid READ_LATENCY cycles after rd_addr.
REQ-010 vga_r, vga_g, vga_b  out  8 each  pixel colour.
REQ-011 vga_hs, vga_vs  out  1 each  sync pulses, active-low.
REQ-012 vga_blank_n  out  1  high during the visible area.
REQ-013 frame_start  out  1  one-cycle pulse at hcnt=0, vcnt=0.

Function
REQ-014 SHALL run a free-running hcnt (0..799) and vcnt (0..524); vcnt increments when hcnt wraps from 799 to 0.
REQ-015 Horizontal timing SHALL be: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-016 Vertical timing SHALL be: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-017 The board window SHALL cover hcnt 80..559 and vcnt 0..479; fb_x = (hcnt-80)>>2 and fb_y = vcnt>>2, giving 4x scaling.
REQ-018 The address SHALL be computed as (fb_x<<7) - (fb_x<<3) + fb_y in 15 bits; the maximum value is 14399 and no overflow is possible.
REQ-019 SHALL register rd_addr and rd_en one cycle after the counter stage; rd_en SHALL be high only for in-window pixels while in state RUN or DRAIN.
REQ-020 SHALL delay hs, vs, blank_n and an in-window flag through a pipeline of depth READ_LATENCY+1, so that colour and sync outputs are aligned.
REQ-021 Total latency from a counter value to the matching pixel on the outputs SHALL be READ_LATENCY+2 cycles.
REQ-022 Output colour SHALL be: rd_data when in window; BG_COLOR when active but outside the window; 0 when blanked.
REQ-023 The FSM SHALL have states IDLE, ARM, RUN and DRAIN.
REQ-024 IDLE SHALL go to ARM when enable=1.
REQ-025 ARM SHALL go to RUN at hcnt=799, vcnt=524, so that the first scanned frame is complete.
REQ-026 RUN SHALL go to DRAIN when enable=0.
REQ-027 DRAIN SHALL go to IDLE at hcnt=799, vcnt=524.
REQ-028 DRAIN SHALL go back to RUN if enable reasserts.
REQ-029 In IDLE and ARM, the colour outputs SHALL be 0, while sync and frame_start keep running.
REQ-030 frame_start SHALL pulse every frame regardless of state.

Reset
REQ-031 On rst=0, SHALL force hcnt=0, vcnt=0, state=IDLE, rd_addr=0, rd_en=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, frame_start=0, and clear all pipeline stages.
REQ-032 Reset asserted mid-frame SHALL take effect immediately; after release, output restarts at hcnt=0 with no partial-frame reads.

Configuration
REQ-033 With macro VGA_FRAME_READER_BORDER_EN defined, pixels at hcnt 76..79 or 560..563 (any active vcnt) SHALL output BORDER_COLOR, and no read SHALL be issued for them.
REQ-034 Without VGA_FRAME_READER_BORDER_EN, those pixels SHALL output BG_COLOR, and the BORDER_COLOR parameter SHALL be unused.

Structure
REQ-035 The shared package SHALL hold the VGA timing constants (H/V active, porch, sync, total), the window origin 80, the scale shift 2, the frame-buffer dimension 120, and the FSM state encoding.
REQ-036 A single sub-module vga_timing_gen SHALL provide hcnt, vcnt, raw hs/vs/active and frame_start; address generation, the FSM and the delay pipeline SHALL live in vga_frame_reader.

Verification
REQ-037 Release reset with enable=0 -> vga_hs low for exactly 96 cycles per 800-cycle line, vga_vs low for 2 lines per 525, colour=0 throughout, rd_en never high.
REQ-038 Set enable=1 mid-frame -> no rd_en until the next frame_start; in the following frame, hcnt=80/vcnt=0 gives rd_addr=0, and hcnt=559/vcnt=479 gives rd_addr=14399.
REQ-039 Memory model returning data=addr, READ_LATENCY=2 -> the pixel at hcnt=84, vcnt=8 appears on vga_r/g/b 4 cycles later as 24'h00007A (addr 122), aligned with its blank_n.
REQ-040 Drop enable during line 200 -> remaining lines still read normally; state is IDLE after hcnt=799/vcnt=524, and the next frame outputs all-zero colour.
REQ-041 Assert rst for 3 cycles at hcnt=300, vcnt=100 -> all outputs take their reset values within the reset window; after release, frame_start pulses 800*525 cycles later.
REQ-042 With VGA_FRAME_READER_BORDER_EN defined and enable=1 -> vga_r/g/b=24'h808080 at hcnt 76..79 and 560..563 with no rd_en; without the macro, BG_COLOR at those positions.
